// File: rtl/fetch_inst_buffer.sv
// Instruction buffer between fetch and the backend: a circular queue that absorbs
// sparse fetch groups (compacted in lane order) and presents up to WIDTH oldest entries.
module fetch_inst_buffer #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_squash_vld,
    input  logic [WIDTH-1:0]                i_enq_vld,
    input  logic [WIDTH-1:0][ENTRY_W-1:0]   i_enq_inst,
    output logic                            o_enq_rdy,
    output logic [WIDTH-1:0]                o_deq_vld,
    output logic [WIDTH-1:0][ENTRY_W-1:0]   o_deq_inst,
    input  logic                            i_stall
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   enq_n;
    logic [CNT_W-1:0]   deq_n;
    logic [IDX_W-1:0]   wr_off;
    logic               enq_fire;
    logic               deq_fire;

    // Readiness looks only at registered occupancy; a same-cycle dequeue never helps.
    assign o_enq_rdy = (PTR_W'(DEPTH) - count_q) >= PTR_W'(WIDTH);

    always_comb begin
        if (count_q >= PTR_W'(WIDTH)) begin
            deq_n = CNT_W'(WIDTH);
        end else begin
            deq_n = CNT_W'(count_q);
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deq_lane
            assign o_deq_vld[gi]  = count_q > PTR_W'(gi);
            assign o_deq_inst[gi] = mem_q[head_q[IDX_W-1:0] + IDX_W'(gi)];
        end
    endgenerate

    always_comb begin
        enq_n = '0;
        for (int k = 0; k < WIDTH; k++) begin
            enq_n = enq_n + CNT_W'(i_enq_vld[k]);
        end
        enq_fire = o_enq_rdy && (|i_enq_vld) && !i_squash_vld;
        deq_fire = !i_stall && !i_squash_vld;

        // The k-th valid lane lands at tail+k; the index wraps naturally at DEPTH.
        mem_d  = mem_q;
        wr_off = '0;
        if (enq_fire) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (i_enq_vld[k]) begin
                    mem_d[tail_q[IDX_W-1:0] + wr_off] = i_enq_inst[k];
                    wr_off = wr_off + IDX_W'(1);
                end
            end
        end

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_squash_vld) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (deq_fire) begin
                head_d = head_q + PTR_W'(deq_n);
            end
            if (enq_fire) begin
                tail_d = tail_q + PTR_W'(enq_n);
            end
            count_d = count_q + (enq_fire ? PTR_W'(enq_n) : '0)
                              - (deq_fire ? PTR_W'(deq_n) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifndef SYNTHESIS
    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count_q <= PTR_W'(DEPTH));
    a_no_enq_when_full : assert property (@(posedge clk) disable iff (rst)
        !o_enq_rdy |-> ((tail_d == tail_q) || i_squash_vld));
`endif

endmodule
